board_occupancy_tracker: RTL and testbench

- Registered, parametrised N×N game-board store for the tic-tac-toe datapath.
- Accepts player moves over a valid/ready handshake and rejects illegal moves.
- Keeps a running occupied-cell count and raises a registered no_space flag when every cell is filled.
- Sits between the move-input controller and the win/draw logic. Successor to the fixed 9-cell combinational full-board detector.

---
 rtl/board_occupancy_tracker.sv | 108 ++++++++++
 tb/tb_board_occupancy_tracker.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/board_occupancy_tracker.sv
// N x N tic-tac-toe board store with valid/ready move intake, legality checks and a registered full flag.
// Optional macro BOARD_TURN_ENFORCE_EN: reject moves whose player does not match the expected turn.
module board_occupancy_tracker #(
  parameter int BOARD_N = 3,
  parameter int IDX_W   = $clog2(BOARD_N*BOARD_N),
  parameter int CNT_W   = $clog2(BOARD_N*BOARD_N+1)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           clear,
  input  logic                           move_valid,
  output logic                           move_ready,
  input  logic [IDX_W-1:0]               move_idx,
  input  logic [1:0]                     move_player,
  output logic                           move_accept,
  output logic                           move_reject,
  output logic [2*BOARD_N*BOARD_N-1:0]   board,
  output logic [CNT_W-1:0]               occupied_count,
  output logic                           no_space,
  output logic [1:0]                     turn
);

  localparam int CELLS = BOARD_N*BOARD_N;

  typedef enum logic {PLAY, FULL} state_t;

  state_t               state_q, state_d;
  logic [2*CELLS-1:0]   board_q, board_d;
  logic [CNT_W-1:0]     count_q, count_d, count_inc;
  logic [1:0]           turn_q, turn_d;
  logic                 accept_q, accept_d;
  logic                 reject_q, reject_d;

  logic [1:0]           cell_cur;
  logic                 idx_in_range;
  logic                 player_ok;
  logic                 turn_ok;
  logic                 legal;
  logic                 take;

  // Legality is judged against the registered board, so a same-cell move on the next cycle is refused.
  always_comb begin
    cell_cur = 2'b00;
    for (int k = 0; k < CELLS; k++) begin
      if (move_idx == IDX_W'(k)) cell_cur = board_q[2*k +: 2];
    end
    idx_in_range = (32'(move_idx) < 32'(CELLS));
    player_ok    = (move_player == 2'b01) || (move_player == 2'b10);
`ifdef BOARD_TURN_ENFORCE_EN
    turn_ok      = (move_player == turn_q);
`else
    turn_ok      = 1'b1;
`endif
    legal        = idx_in_range && (cell_cur == 2'b00) && player_ok && turn_ok;
    take         = move_valid && (state_q == PLAY);
    count_inc    = count_q + CNT_W'(1);
  end

  always_comb begin
    state_d    = state_q;
    board_d    = board_q;
    count_d    = count_q;
    turn_d     = turn_q;
    accept_d   = 1'b0;
    reject_d   = 1'b0;
    move_ready = (state_q == PLAY);
    if (take) begin
      if (legal) begin
        for (int k = 0; k < CELLS; k++) begin
          if (move_idx == IDX_W'(k)) board_d[2*k +: 2] = move_player;
        end
        count_d  = count_inc;
        turn_d   = ~turn_q;
        accept_d = 1'b1;
        if (count_inc == CNT_W'(CELLS)) state_d = FULL;
      end else begin
        reject_d = 1'b1;
      end
    end
  end

  // Clear wipes exactly like reset; a move arriving alongside either is dropped.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      state_q  <= PLAY;
      board_q  <= '0;
      count_q  <= '0;
      turn_q   <= 2'b01;
      accept_q <= 1'b0;
      reject_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      board_q  <= board_d;
      count_q  <= count_d;
      turn_q   <= turn_d;
      accept_q <= accept_d;
      reject_q <= reject_d;
    end
  end

  assign board          = board_q;
  assign occupied_count = count_q;
  assign no_space       = (state_q == FULL);
  assign turn           = turn_q;
  assign move_accept    = accept_q;
  assign move_reject    = reject_q;

endmodule

// File: tb/tb_board_occupancy_tracker.sv
// Bench for board_occupancy_tracker: directed table, corner sequences, random run vs. a cell-array model, and a 4x4 fill.
module tb_board_occupancy_tracker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 3x3 instance
  logic        reset, clear, move_valid, move_ready, move_accept, move_reject, no_space;
  logic [3:0]  move_idx, occupied_count;
  logic [1:0]  move_player, turn;
  logic [17:0] board;

  board_occupancy_tracker #(.BOARD_N(3)) dut3 (
    .clk(clk), .reset(reset), .clear(clear), .move_valid(move_valid), .move_ready(move_ready),
    .move_idx(move_idx), .move_player(move_player), .move_accept(move_accept),
    .move_reject(move_reject), .board(board), .occupied_count(occupied_count),
    .no_space(no_space), .turn(turn));

  // 4x4 instance
  logic        r4, c4, v4, rdy4, acc4, rej4, ns4;
  logic [3:0]  idx4;
  logic [1:0]  p4, turn4;
  logic [4:0]  cnt4;
  logic [31:0] board4;

  board_occupancy_tracker #(.BOARD_N(4)) dut4 (
    .clk(clk), .reset(r4), .clear(c4), .move_valid(v4), .move_ready(rdy4),
    .move_idx(idx4), .move_player(p4), .move_accept(acc4),
    .move_reject(rej4), .board(board4), .occupied_count(cnt4),
    .no_space(ns4), .turn(turn4));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: the board as a plain array of owners
  int         m_cells [9];
  logic [1:0] m_turn;
  logic       m_acc, m_rej;

  function automatic int m_count();
    int n = 0;
    for (int k = 0; k < 9; k++) if (m_cells[k] != 0) n++;
    return n;
  endfunction

  task automatic model_step(input logic r, input logic c, input logic v,
                            input logic [3:0] i, input logic [1:0] p);
    bit ok;
    if (r || c) begin
      for (int k = 0; k < 9; k++) m_cells[k] = 0;
      m_turn = 2'b01; m_acc = 1'b0; m_rej = 1'b0;
    end else begin
      m_acc = 1'b0; m_rej = 1'b0;
      if (v && m_count() < 9) begin
        ok = (int'(i) < 9) && (p == 2'b01 || p == 2'b10);
        if (ok) ok = (m_cells[i] == 0);
`ifdef BOARD_TURN_ENFORCE_EN
        if (p != m_turn) ok = 1'b0;
`endif
        if (ok) begin
          m_cells[i] = int'(p);
          m_turn = (m_turn == 2'b01) ? 2'b10 : 2'b01;
          m_acc = 1'b1;
        end else begin
          m_rej = 1'b1;
        end
      end
    end
  endtask

  task automatic check_model(input string tag);
    logic [17:0] mb = '0;
    for (int k = 0; k < 9; k++) mb[2*k +: 2] = m_cells[k][1:0];
    chk({tag, "_board"}, 32'(board), 32'(mb));
    chk({tag, "_count"}, 32'(occupied_count), 32'(m_count()));
    chk({tag, "_nospace"}, 32'(no_space), 32'(m_count() == 9));
    chk({tag, "_ready"}, 32'(move_ready), 32'(m_count() != 9));
    chk({tag, "_accept"}, 32'(move_accept), 32'(m_acc));
    chk({tag, "_reject"}, 32'(move_reject), 32'(m_rej));
    chk({tag, "_turn"}, 32'(turn), 32'(m_turn));
  endtask

  task automatic step3(input logic r, input logic c, input logic v,
                       input logic [3:0] i, input logic [1:0] p);
    reset = r; clear = c; move_valid = v; move_idx = i; move_player = p;
    @(posedge clk);
    model_step(r, c, v, i, p);
    #1;
  endtask

  task automatic step4(input logic r, input logic c, input logic v,
                       input logic [3:0] i, input logic [1:0] p);
    r4 = r; c4 = c; v4 = v; idx4 = i; p4 = p;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic r, c, v;
    logic [3:0] idx;
    logic [1:0] pl;
    logic [17:0] b;
    logic [3:0] cnt;
    logic acc, rej, ns, rdy;
    logic [1:0] trn;
  } vec_t;

  vec_t tbl [9];

  initial begin
    reset = 1'b1; clear = 1'b0; move_valid = 1'b0; move_idx = '0; move_player = '0;
    r4 = 1'b1; c4 = 1'b0; v4 = 1'b0; idx4 = '0; p4 = '0;
    for (int k = 0; k < 9; k++) m_cells[k] = 0;
    m_turn = 2'b01; m_acc = 1'b0; m_rej = 1'b0;

    //          r     c     v     idx    pl     board       cnt   acc   rej   ns    rdy   turn
    tbl[0] = '{1'b1, 1'b0, 1'b0, 4'd0, 2'b00, 18'h00000, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01};
    tbl[1] = '{1'b1, 1'b0, 1'b0, 4'd0, 2'b00, 18'h00000, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01};
    tbl[2] = '{1'b0, 1'b0, 1'b0, 4'd0, 2'b00, 18'h00000, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01};
    tbl[3] = '{1'b0, 1'b0, 1'b1, 4'd4, 2'b01, 18'h00100, 4'd1, 1'b1, 1'b0, 1'b0, 1'b1, 2'b10};
    tbl[4] = '{1'b0, 1'b0, 1'b0, 4'd0, 2'b00, 18'h00100, 4'd1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10};
    tbl[5] = '{1'b0, 1'b0, 1'b1, 4'd4, 2'b10, 18'h00100, 4'd1, 1'b0, 1'b1, 1'b0, 1'b1, 2'b10};
    tbl[6] = '{1'b0, 1'b0, 1'b1, 4'd9, 2'b10, 18'h00100, 4'd1, 1'b0, 1'b1, 1'b0, 1'b1, 2'b10};
    tbl[7] = '{1'b0, 1'b0, 1'b1, 4'd0, 2'b11, 18'h00100, 4'd1, 1'b0, 1'b1, 1'b0, 1'b1, 2'b10};
    tbl[8] = '{1'b0, 1'b0, 1'b0, 4'd0, 2'b00, 18'h00100, 4'd1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10};

    for (int i = 0; i < 9; i++) begin
      step3(tbl[i].r, tbl[i].c, tbl[i].v, tbl[i].idx, tbl[i].pl);
      chk($sformatf("tbl%0d_board", i), 32'(board), 32'(tbl[i].b));
      chk($sformatf("tbl%0d_count", i), 32'(occupied_count), 32'(tbl[i].cnt));
      chk($sformatf("tbl%0d_accept", i), 32'(move_accept), 32'(tbl[i].acc));
      chk($sformatf("tbl%0d_reject", i), 32'(move_reject), 32'(tbl[i].rej));
      chk($sformatf("tbl%0d_nospace", i), 32'(no_space), 32'(tbl[i].ns));
      chk($sformatf("tbl%0d_ready", i), 32'(move_ready), 32'(tbl[i].rdy));
      chk($sformatf("tbl%0d_turn", i), 32'(turn), 32'(tbl[i].trn));
    end

    // Back-to-back fill of the remaining eight cells
    for (int k = 0; k < 9; k++) begin
      if (k != 4) begin
        step3(1'b0, 1'b0, 1'b1, 4'(k), m_turn);
        check_model("fill");
      end
    end
    chk("full_count", 32'(occupied_count), 32'd9);
    chk("full_nospace", 32'(no_space), 32'd1);
    chk("full_ready", 32'(move_ready), 32'd0);
    step3(1'b0, 1'b0, 1'b1, 4'd0, 2'b01);
    chk("full_ignore_acc", 32'(move_accept), 32'd0);
    chk("full_ignore_rej", 32'(move_reject), 32'd0);
    chk("full_ignore_cnt", 32'(occupied_count), 32'd9);
    step3(1'b0, 1'b1, 1'b1, 4'd0, 2'b01);
    chk("clr_board", 32'(board), 32'd0);
    chk("clr_count", 32'(occupied_count), 32'd0);
    chk("clr_nospace", 32'(no_space), 32'd0);
    chk("clr_acc", 32'(move_accept), 32'd0);
    chk("clr_ready", 32'(move_ready), 32'd1);

    // Second move to a cell written on the previous edge, then reset during the pulse
    step3(1'b0, 1'b0, 1'b1, 4'd2, 2'b01);
    chk("b2b_first_acc", 32'(move_accept), 32'd1);
    step3(1'b0, 1'b0, 1'b1, 4'd2, 2'b10);
    chk("b2b_same_rej", 32'(move_reject), 32'd1);
    chk("b2b_same_acc", 32'(move_accept), 32'd0);
    step3(1'b1, 1'b0, 1'b0, 4'd0, 2'b00);
    chk("rst_drops_pulse", 32'(move_reject), 32'd0);
    check_model("rst");

    // Turn order from reset
    step3(1'b0, 1'b0, 1'b1, 4'd0, 2'b10);
`ifdef BOARD_TURN_ENFORCE_EN
    chk("turn_first_rej", 32'(move_reject), 32'd1);
    chk("turn_first_acc", 32'(move_accept), 32'd0);
`else
    chk("turn_first_rej", 32'(move_reject), 32'd0);
    chk("turn_first_acc", 32'(move_accept), 32'd1);
`endif
    step3(1'b0, 1'b0, 1'b1, 4'd1, 2'b01);
    chk("turn_second_acc", 32'(move_accept), 32'd1);
    check_model("turn");

    // Randomized run against the model
    for (int n = 0; n < 800; n++) begin
      logic r, c, v;
      logic [3:0] i;
      logic [1:0] p;
      r = ($urandom_range(0, 99) == 0);
      c = ($urandom_range(0, 39) == 0);
      v = ($urandom_range(0, 3) != 0);
      i = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8));
      p = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(0, 3)) : m_turn;
      step3(r, c, v, i, p);
      check_model("rand");
    end

    // 4x4 board fill
    step4(1'b1, 1'b0, 1'b0, 4'd0, 2'b00);
    step4(1'b1, 1'b0, 1'b0, 4'd0, 2'b00);
    chk("n4_reset_count", 32'(cnt4), 32'd0);
    chk("n4_reset_ready", 32'(rdy4), 32'd1);
    for (int k = 0; k < 16; k++) begin
      step4(1'b0, 1'b0, 1'b1, 4'(k), (k % 2 == 0) ? 2'b01 : 2'b10);
      chk($sformatf("n4_fill%0d_acc", k), 32'(acc4), 32'd1);
    end
    chk("n4_full_count", 32'(cnt4), 32'd16);
    chk("n4_full_nospace", 32'(ns4), 32'd1);
    chk("n4_full_ready", 32'(rdy4), 32'd0);
    chk("n4_full_board", board4, 32'h99999999);
    step4(1'b0, 1'b1, 1'b1, 4'd0, 2'b01);
    chk("n4_clr_count", 32'(cnt4), 32'd0);
    chk("n4_clr_nospace", 32'(ns4), 32'd0);
    chk("n4_clr_board", board4, 32'd0);
    chk("n4_clr_acc", 32'(acc4), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
